// File: rtl/req_grant_arbiter.sv
// req_grant_arbiter: round-robin arbiter sharing one downstream req/grant
// fetch port between master_n requesters. A winner is latched in IDLE and
// held in REQ until the downstream grants or the timeout aborts it.
module req_grant_arbiter #(
    parameter int master_n       = 3,
    parameter int addr_width     = 32,
    parameter int data_width     = 32,
    parameter int timeout_cycles = 64
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [master_n-1:0]            m_req,
    input  logic [master_n*addr_width-1:0] m_addr,
    output logic [master_n-1:0]            m_grant,
    output logic [data_width-1:0]          m_rdata,
    output logic                           s_req,
    output logic [addr_width-1:0]          s_addr,
    input  logic                           s_grant,
    input  logic [data_width-1:0]          s_rdata,
    output logic                           busy,
    output logic [2:0]                     cur_master,
    output logic                           timeout_err,
    output logic [2:0]                     err_master
);

    localparam int IW = 3;
    localparam bit TMO_EN = (timeout_cycles != 0);
    localparam int TW = (timeout_cycles > 1) ? $clog2(timeout_cycles) : 1;
    localparam logic [TW-1:0] TMO_LAST = TW'((timeout_cycles > 0) ? timeout_cycles - 1 : 0);

    typedef enum logic {ST_IDLE, ST_REQ} state_t;

    state_t                r_state;
    state_t                w_next_state;
    logic [IW-1:0]         r_rr_ptr;
    logic [IW-1:0]         r_win_idx;
    logic [addr_width-1:0] r_addr;
    logic [TW-1:0]         r_tmo_cnt;
    logic                  r_tmo_err;
    logic [IW-1:0]         r_err_master;

    logic [IW-1:0]         w_win_hi;
    logic [IW-1:0]         w_win_lo;
    logic                  w_found_hi;
    logic [IW-1:0]         w_winner;
    logic [addr_width-1:0] w_win_addr;
    logic                  w_any_req;
    logic                  w_abort;
    logic                  w_in_req;
    logic [IW-1:0]         w_next_ptr;

    // Rotating priority: lowest requester at or above rr_ptr, else lowest overall (wrap).
    always_comb begin
        w_win_hi   = '0;
        w_win_lo   = '0;
        w_found_hi = 1'b0;
        for (int i = master_n - 1; i >= 0; i--) begin
            if (m_req[i]) begin
                w_win_lo = IW'(i);
                if (IW'(i) >= r_rr_ptr) begin
                    w_win_hi   = IW'(i);
                    w_found_hi = 1'b1;
                end
            end
        end
        w_winner   = w_found_hi ? w_win_hi : w_win_lo;
        w_win_addr = '0;
        for (int i = 0; i < master_n; i++) begin
            if (w_winner == IW'(i)) w_win_addr = m_addr[i*addr_width +: addr_width];
        end
    end

    assign w_any_req  = |m_req;
    assign w_in_req   = (r_state == ST_REQ);
    assign w_abort    = TMO_EN && w_in_req && !s_grant && (r_tmo_cnt == TMO_LAST);
    assign w_next_ptr = (r_win_idx == IW'(master_n - 1)) ? '0 : r_win_idx + IW'(1);

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= ST_IDLE;
        else     r_state <= w_next_state;
    end

    // Next-state logic: leave REQ on grant (grant beats a coincident timeout) or abort.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE: if (w_any_req) w_next_state = ST_REQ;
            ST_REQ:  if (s_grant || w_abort) w_next_state = ST_IDLE;
            default: w_next_state = ST_IDLE;
        endcase
    end

    // Output logic: grant and payload are routed combinationally to the latched winner.
    always_comb begin
        s_req       = w_in_req;
        busy        = w_in_req;
        cur_master  = w_in_req ? r_win_idx : '0;
        s_addr      = r_addr;
        m_rdata     = s_rdata;
        timeout_err = r_tmo_err;
        err_master  = r_err_master;
        m_grant     = '0;
        for (int i = 0; i < master_n; i++) begin
            if (w_in_req && (r_win_idx == IW'(i))) m_grant[i] = s_grant;
        end
    end

    // Winner latch in IDLE; round-robin pointer advances past the winner when REQ ends.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_win_idx <= '0;
            r_addr    <= '0;
            r_rr_ptr  <= '0;
        end else if (!w_in_req) begin
            if (w_any_req) begin
                r_win_idx <= w_winner;
                r_addr    <= w_win_addr;
            end
        end else if (s_grant || w_abort) begin
            r_rr_ptr <= w_next_ptr;
        end
    end

    // Timeout counter (saturating), one-cycle abort pulse and sticky aborted-master index.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_tmo_cnt    <= '0;
            r_tmo_err    <= 1'b0;
            r_err_master <= '0;
        end else begin
            r_tmo_err <= w_abort;
            if (!w_in_req)            r_tmo_cnt <= '0;
            else if (r_tmo_cnt != '1) r_tmo_cnt <= r_tmo_cnt + TW'(1);
            if (w_abort) r_err_master <= r_win_idx;
        end
    end

endmodule

// File: tb/tb_req_grant_arbiter.sv
// Directed bench for req_grant_arbiter (3 masters, timeout of 4 cycles).
module tb_req_grant_arbiter;

    localparam int MN = 3;
    localparam int AW = 32;
    localparam int DW = 32;

    logic              clk = 1'b0;
    logic              rst;
    logic [MN-1:0]     m_req;
    logic [MN*AW-1:0]  m_addr;
    logic [MN-1:0]     m_grant;
    logic [DW-1:0]     m_rdata;
    logic              s_req;
    logic [AW-1:0]     s_addr;
    logic              s_grant;
    logic [DW-1:0]     s_rdata;
    logic              busy;
    logic [2:0]        cur_master;
    logic              timeout_err;
    logic [2:0]        err_master;

    int n_cmp  = 0;
    int n_fail = 0;

    req_grant_arbiter #(
        .master_n(MN), .addr_width(AW), .data_width(DW), .timeout_cycles(4)
    ) dut (
        .clk(clk), .rst(rst), .m_req(m_req), .m_addr(m_addr),
        .m_grant(m_grant), .m_rdata(m_rdata), .s_req(s_req), .s_addr(s_addr),
        .s_grant(s_grant), .s_rdata(s_rdata), .busy(busy), .cur_master(cur_master),
        .timeout_err(timeout_err), .err_master(err_master)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst     = 1'b1;
        m_req   = '0;
        m_addr  = '0;
        s_grant = 1'b0;
        s_rdata = '0;
        tick();
        tick();
        chk("rst_s_req", s_req, 0);
        chk("rst_m_grant", m_grant, 0);
        chk("rst_busy", busy, 0);
        chk("rst_tmo_err", timeout_err, 0);
        chk("rst_cur_master", cur_master, 0);
        chk("rst_err_master", err_master, 0);
        rst = 1'b0;

        // Fairness: all request, zero-wait grant -> 0,1,2,0,1,2 every 2 cycles.
        m_req   = 3'b111;
        s_grant = 1'b1;
        for (int k = 0; k < 6; k++) begin
            tick();
            chk("rr_s_req", s_req, 1);
            chk("rr_cur_master", cur_master, k % 3);
            chk("rr_m_grant", m_grant, 3'b001 << (k % 3));
            tick();
            chk("rr_idle_s_req", s_req, 0);
            chk("rr_idle_m_grant", m_grant, 0);
        end
        m_req   = '0;
        s_grant = 1'b0;
        tick();

        // Single master 1, grant after 2 cycles.
        m_req[1]        = 1'b1;
        m_addr[AW +: AW] = 32'h7E0;
        #1;
        chk("t1_idle_s_req", s_req, 0);
        tick();
        chk("t1_s_req", s_req, 1);
        chk("t1_s_addr", s_addr, 32'h7E0);
        chk("t1_busy", busy, 1);
        chk("t1_cur_master", cur_master, 1);
        chk("t1_no_grant", m_grant, 0);
        tick();
        s_grant = 1'b1;
        s_rdata = 32'h13;
        #1;
        chk("t1_m_grant", m_grant, 3'b010);
        chk("t1_m_rdata", m_rdata, 32'h13);
        m_req = '0;
        tick();
        chk("t1_done_s_req", s_req, 0);
        chk("t1_idle_grant_ignored", m_grant, 0);
        s_grant = 1'b0;

        // rr_ptr now 2: masters 0 and 1 request -> 0 then 1.
        m_req = 3'b011;
        tick();
        chk("t3_first", cur_master, 0);
        s_grant = 1'b1;
        #1;
        chk("t3_first_grant", m_grant, 3'b001);
        m_req = 3'b010;
        tick();
        s_grant = 1'b0;
        tick();
        chk("t3_second", cur_master, 1);
        s_grant = 1'b1;
        #1;
        chk("t3_second_grant", m_grant, 3'b010);
        m_req = '0;
        tick();
        s_grant = 1'b0;

        // Timeout: rr_ptr 2, masters 0 and 2 request, no grant.
        m_req = 3'b101;
        for (int k = 0; k < 4; k++) begin
            tick();
            chk("t4_s_req_held", s_req, 1);
            chk("t4_cur_master", cur_master, 2);
            chk("t4_no_err_yet", timeout_err, 0);
        end
        tick();
        chk("t4_s_req_drop", s_req, 0);
        chk("t4_tmo_err", timeout_err, 1);
        chk("t4_err_master", err_master, 2);
        tick();
        chk("t4_next_winner", cur_master, 0);
        chk("t4_tmo_pulse_end", timeout_err, 0);
        chk("t4_err_master_hold", err_master, 2);
        s_grant = 1'b1;
        m_req   = 3'b100;
        tick();
        s_grant = 1'b0;

        // Grant in the final timeout cycle wins, no error.
        tick();
        chk("t5_cur_master", cur_master, 2);
        tick();
        tick();
        tick();
        s_grant = 1'b1;
        s_rdata = 32'h55;
        #1;
        chk("t5_m_grant", m_grant, 3'b100);
        chk("t5_m_rdata", m_rdata, 32'h55);
        m_req = 3'b001;
        tick();
        chk("t5_no_tmo_err", timeout_err, 0);
        chk("t5_s_req", s_req, 0);
        s_grant = 1'b0;

        // Master 0 granted (rr_ptr -> 1), then reset asynchronously mid-REQ of master 1.
        tick();
        chk("t6_pre_cur", cur_master, 0);
        s_grant = 1'b1;
        m_req   = 3'b010;
        tick();
        s_grant = 1'b0;
        tick();
        chk("t6_req_cur", cur_master, 1);
        s_grant = 1'b1;
        #1;
        chk("t6_pre_grant", m_grant, 3'b010);
        #2;
        rst = 1'b1;
        #1;
        chk("t6_async_s_req", s_req, 0);
        chk("t6_async_m_grant", m_grant, 0);
        chk("t6_async_busy", busy, 0);
        chk("t6_async_cur", cur_master, 0);
        chk("t6_async_err_master", err_master, 0);
        s_grant = 1'b0;
        tick();
        rst   = 1'b0;
        m_req = 3'b111;
        tick();
        chk("t6_restart_master0", cur_master, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
